mc_delay_ctrl: RTL and testbench



---
 rtl/mc_delay_ctrl.sv | 129 ++++++++++++
 tb/tb_mc_delay_ctrl.sv | 299 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mc_delay_ctrl.sv
// Delay-line code sequencer: ramps one line's delay-select code toward a target one LSB per step,
// dwelling SettleCycles after each step. Optional macro MC_DELAY_CTRL_LOCK_EN adds lock_i.
module mc_delay_ctrl #(
   parameter int unsigned NumLines     = 2,
   parameter int unsigned DelayWidth   = 4,
   parameter int unsigned SettleCycles = 8,
   parameter int unsigned ResetDelay   = 0,
   parameter int unsigned LineIdxWidth = (NumLines > 1) ? $clog2(NumLines) : 1
) (
   input  logic                             clk_i,
   input  logic                             rst_ni,
`ifdef MC_DELAY_CTRL_LOCK_EN
   input  logic                             lock_i,
`endif
   input  logic                             req_valid_i,
   output logic                             req_ready_o,
   input  logic [LineIdxWidth-1:0]          req_line_i,
   input  logic [DelayWidth-1:0]            req_delay_i,
   output logic [NumLines*DelayWidth-1:0]   delay_o,
   output logic                             busy_o,
   output logic                             done_o,
   output logic                             err_o
);

   localparam int unsigned CntWidth = (SettleCycles > 1) ? $clog2(SettleCycles) : 1;
   localparam logic [CntWidth-1:0]     SettleLoad  = CntWidth'(SettleCycles - 1);
   localparam logic [DelayWidth-1:0]   ResetCode   = DelayWidth'(ResetDelay);
   localparam logic [LineIdxWidth:0]   NumLinesExt = (LineIdxWidth + 1)'(NumLines);

   typedef enum logic [1:0] {StIdle, StStep, StSettle, StDone} state_e;

   state_e                                 state_q;
   logic [LineIdxWidth-1:0]                line_q;
   logic [DelayWidth-1:0]                  target_q;
   logic [CntWidth-1:0]                    cnt_q;
   logic [NumLines-1:0][DelayWidth-1:0]    code_q;
   logic                                   ready_q;
   logic                                   busy_q;
   logic                                   done_q;
   logic                                   err_q;

   logic                                   accept;
   logic                                   line_bad;
   logic [DelayWidth-1:0]                  req_code;
   logic [DelayWidth-1:0]                  cur_code;

`ifdef MC_DELAY_CTRL_LOCK_EN
   // Lock only gates new acceptances; an in-flight ramp is unaffected.
   assign req_ready_o = ready_q & ~lock_i;
`else
   assign req_ready_o = ready_q;
`endif

   assign accept   = req_valid_i & req_ready_o;
   assign line_bad = {1'b0, req_line_i} >= NumLinesExt;
   assign req_code = code_q[req_line_i];
   assign cur_code = code_q[line_q];

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q  <= StIdle;
         line_q   <= '0;
         target_q <= '0;
         cnt_q    <= '0;
         code_q   <= {NumLines{ResetCode}};
         ready_q  <= 1'b1;
         busy_q   <= 1'b0;
         done_q   <= 1'b0;
         err_q    <= 1'b0;
      end else begin
         done_q <= 1'b0;
         err_q  <= 1'b0;
         unique case (state_q)
            StIdle: begin
               if (accept) begin
                  line_q   <= req_line_i;
                  target_q <= req_delay_i;
                  ready_q  <= 1'b0;
                  if (line_bad) begin
                     err_q   <= 1'b1;
                     done_q  <= 1'b1;
                     state_q <= StDone;
                  end else if (req_delay_i == req_code) begin
                     done_q  <= 1'b1;
                     state_q <= StDone;
                  end else begin
                     busy_q  <= 1'b1;
                     state_q <= StStep;
                  end
               end
            end
            StStep: begin
               // Single-LSB move; target differs from current here, so no wrap is possible.
               if (target_q > cur_code) begin
                  code_q[line_q] <= cur_code + 1'b1;
               end else begin
                  code_q[line_q] <= cur_code - 1'b1;
               end
               cnt_q   <= SettleLoad;
               state_q <= StSettle;
            end
            StSettle: begin
               if (cnt_q == '0) begin
                  if (cur_code == target_q) begin
                     busy_q  <= 1'b0;
                     done_q  <= 1'b1;
                     state_q <= StDone;
                  end else begin
                     state_q <= StStep;
                  end
               end else begin
                  cnt_q <= cnt_q - 1'b1;
               end
            end
            StDone: begin
               ready_q <= 1'b1;
               state_q <= StIdle;
            end
            default: state_q <= StIdle;
         endcase
      end
   end

   assign delay_o = code_q;
   assign busy_o  = busy_q;
   assign done_o  = done_q;
   assign err_o   = err_q;

endmodule

// File: tb/tb_mc_delay_ctrl.sv
// Self-checking bench for mc_delay_ctrl: directed and random ramps checked cycle by cycle
// against a step-count model derived from the latency rules.
module tb_mc_delay_ctrl;

   localparam int unsigned NL = 3;
   localparam int unsigned DW = 4;
   localparam int unsigned SC = 8;
   localparam int unsigned RD = 0;
   localparam int unsigned LW = 2;

   logic              clk = 1'b0;
   logic              rst_n = 1'b1;
   logic              valid = 1'b0;
   logic              ready;
   logic [LW-1:0]     line = '0;
   logic [DW-1:0]     dly = '0;
   logic [NL*DW-1:0]  delay;
   logic              busy;
   logic              done;
   logic              err;
`ifdef MC_DELAY_CTRL_LOCK_EN
   logic              lock = 1'b0;
`endif

   int checks = 0;
   int failures = 0;
   int model[NL];

   mc_delay_ctrl #(
      .NumLines     (NL),
      .DelayWidth   (DW),
      .SettleCycles (SC),
      .ResetDelay   (RD)
   ) dut (
      .clk_i       (clk),
      .rst_ni      (rst_n),
`ifdef MC_DELAY_CTRL_LOCK_EN
      .lock_i      (lock),
`endif
      .req_valid_i (valid),
      .req_ready_o (ready),
      .req_line_i  (line),
      .req_delay_i (dly),
      .delay_o     (delay),
      .busy_o      (busy),
      .done_o      (done),
      .err_o       (err)
   );

   always #5 clk = ~clk;

   initial begin
      #1000000;
      $display("FAIL watchdog timeout checks=%0d", checks);
      $fatal(1);
   end

   function automatic logic [NL*DW-1:0] pack_model();
      logic [NL*DW-1:0] v;
      for (int i = 0; i < NL; i++) v[i*DW +: DW] = DW'(model[i]);
      return v;
   endfunction

   task automatic test_reset();
      #2 rst_n = 1'b0;
      #1;
      checks++;
      if (delay !== '0) begin failures++; $display("FAIL reset_delay got=%0h exp=0", delay); end
      checks++;
      if ({ready, busy, done, err} !== 4'b1000) begin
         failures++; $display("FAIL reset_flags got=%b exp=1000", {ready, busy, done, err});
      end
      for (int i = 0; i < NL; i++) model[i] = RD;
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
   endtask

   task automatic test_ramps();
      int ln[7] = '{0, 1, 1, 2, 2, 2, 2};
      int tg[7] = '{3, 3, 1, 7, 8, 15, 14};
      int l, t, cur, d, sgn, dcyc, steps;
      logic [NL*DW-1:0] exp_vec;
      for (int r = 0; r < 19; r++) begin
         if (r < 7) begin
            l = ln[r]; t = tg[r];
         end else begin
            l = int'($urandom_range(NL - 1)); t = int'($urandom_range(15));
         end
         cur  = model[l];
         d    = (t > cur) ? t - cur : cur - t;
         sgn  = (t > cur) ? 1 : -1;
         dcyc = d * (1 + SC) + 1;
         @(negedge clk);
         valid = 1'b1; line = LW'(l); dly = DW'(t);
         checks++;
         if (ready !== 1'b1) begin failures++; $display("FAIL ramp_ready r=%0d got=%b exp=1", r, ready); end
         @(posedge clk);
         #1 valid = 1'b0; line = LW'($urandom); dly = DW'($urandom);
         for (int c = 1; c <= dcyc + 1; c++) begin
            @(negedge clk);
            steps = (c >= 2) ? ((c - 2) / (SC + 1) + 1) : 0;
            if (steps > d) steps = d;
            exp_vec = pack_model();
            exp_vec[l*DW +: DW] = DW'(cur + sgn * steps);
            checks++;
            if (delay !== exp_vec) begin
               failures++; $display("FAIL ramp_delay r=%0d c=%0d got=%0h exp=%0h", r, c, delay, exp_vec);
            end
            checks++;
            if (done !== (c == dcyc)) begin
               failures++; $display("FAIL ramp_done r=%0d c=%0d got=%b exp=%b", r, c, done, c == dcyc);
            end
            checks++;
            if (err !== 1'b0) begin failures++; $display("FAIL ramp_err r=%0d c=%0d got=%b exp=0", r, c, err); end
            checks++;
            if (ready !== (c > dcyc)) begin
               failures++; $display("FAIL ramp_ready_cyc r=%0d c=%0d got=%b exp=%b", r, c, ready, c > dcyc);
            end
            checks++;
            if (busy !== (c < dcyc)) begin
               failures++; $display("FAIL ramp_busy r=%0d c=%0d got=%b exp=%b", r, c, busy, c < dcyc);
            end
         end
         model[l] = t;
      end
   endtask

   task automatic test_same_and_bad();
      logic [NL*DW-1:0] exp_vec;
      exp_vec = pack_model();
      // Same code: completes in cycle 1 with no movement.
      @(negedge clk);
      valid = 1'b1; line = 2'd0; dly = DW'(model[0]);
      @(posedge clk);
      #1 valid = 1'b0;
      @(negedge clk);
      checks++;
      if ({done, err, busy, ready} !== 4'b1000) begin
         failures++; $display("FAIL same_flags got=%b exp=1000", {done, err, busy, ready});
      end
      checks++;
      if (delay !== exp_vec) begin failures++; $display("FAIL same_delay got=%0h exp=%0h", delay, exp_vec); end
      @(negedge clk);
      checks++;
      if ({done, ready} !== 2'b01) begin failures++; $display("FAIL same_after got=%b exp=01", {done, ready}); end
      // Out-of-range line index: rejected with err in cycle 1.
      valid = 1'b1; line = 2'd3; dly = DW'(model[0] ^ 5);
      @(posedge clk);
      #1 valid = 1'b0;
      @(negedge clk);
      checks++;
      if ({done, err, busy, ready} !== 4'b1100) begin
         failures++; $display("FAIL bad_flags got=%b exp=1100", {done, err, busy, ready});
      end
      checks++;
      if (delay !== exp_vec) begin failures++; $display("FAIL bad_delay got=%0h exp=%0h", delay, exp_vec); end
      @(negedge clk);
      checks++;
      if ({done, err, ready} !== 3'b001) begin
         failures++; $display("FAIL bad_after got=%b exp=001", {done, err, ready});
      end
   endtask

   task automatic test_back_to_back();
      int ta, tb, first, second;
      logic rdy11;
      logic [NL*DW-1:0] exp_vec;
      ta = (model[0] == 15) ? 14 : model[0] + 1;
      tb = (model[1] >= 2) ? model[1] - 2 : model[1] + 2;
      first = -1; second = -1; rdy11 = 1'b0;
      @(negedge clk);
      valid = 1'b1; line = 2'd0; dly = DW'(ta);
      @(posedge clk);
      #1 line = 2'd1; dly = DW'(tb);
      for (int c = 1; c <= 60; c++) begin
         @(negedge clk);
         if (c == 11) rdy11 = ready;
         if (c == 12) valid = 1'b0;
         if (done === 1'b1) begin
            if (first < 0) first = c;
            else if (second < 0) second = c;
         end
      end
      checks++;
      if (first != 10) begin failures++; $display("FAIL b2b_first_done got=%0d exp=10", first); end
      checks++;
      if (rdy11 !== 1'b1) begin failures++; $display("FAIL b2b_ready_idle got=%b exp=1", rdy11); end
      checks++;
      if (second != 30) begin failures++; $display("FAIL b2b_second_done got=%0d exp=30", second); end
      model[0] = ta; model[1] = tb;
      exp_vec = pack_model();
      checks++;
      if (delay !== exp_vec) begin failures++; $display("FAIL b2b_delay got=%0h exp=%0h", delay, exp_vec); end
   endtask

   task automatic test_abort();
      int t, cur;
      logic seen_done;
      logic [NL*DW-1:0] exp_vec;
      cur = model[1];
      t = (cur < 8) ? 15 : 0;
      @(negedge clk);
      valid = 1'b1; line = 2'd1; dly = DW'(t);
      @(posedge clk);
      #1 valid = 1'b0;
      repeat (5) @(negedge clk);
      exp_vec = pack_model();
      exp_vec[DW +: DW] = DW'((t > cur) ? cur + 1 : cur - 1);
      checks++;
      if (delay !== exp_vec) begin failures++; $display("FAIL abort_first_step got=%0h exp=%0h", delay, exp_vec); end
      #2 rst_n = 1'b0;
      #1;
      for (int i = 0; i < NL; i++) model[i] = RD;
      exp_vec = pack_model();
      checks++;
      if (delay !== exp_vec) begin failures++; $display("FAIL abort_delay got=%0h exp=%0h", delay, exp_vec); end
      checks++;
      if ({ready, busy, done, err} !== 4'b1000) begin
         failures++; $display("FAIL abort_flags got=%b exp=1000", {ready, busy, done, err});
      end
      @(negedge clk);
      rst_n = 1'b1;
      seen_done = 1'b0;
      repeat (30) begin
         @(negedge clk);
         if (done !== 1'b0 || ready !== 1'b1) seen_done = 1'b1;
      end
      checks++;
      if (seen_done) begin failures++; $display("FAIL abort_no_done got=1 exp=0"); end
   endtask

`ifdef MC_DELAY_CTRL_LOCK_EN
   task automatic test_lock();
      int t, dcyc;
      logic bad;
      logic [NL*DW-1:0] exp_vec;
      t = model[0] ^ 1;
      exp_vec = pack_model();
      @(negedge clk);
      lock = 1'b1; valid = 1'b1; line = 2'd0; dly = DW'(t);
      bad = 1'b0;
      repeat (5) begin
         #1 if (ready !== 1'b0 || busy !== 1'b0 || delay !== exp_vec) bad = 1'b1;
         @(negedge clk);
      end
      checks++;
      if (bad) begin failures++; $display("FAIL lock_idle_accept got=1 exp=0"); end
      lock = 1'b0;
      #1;
      checks++;
      if (ready !== 1'b1) begin failures++; $display("FAIL lock_release_ready got=%b exp=1", ready); end
      @(posedge clk);
      #1 valid = 1'b0;
      dcyc = -1;
      for (int c = 1; c <= 40; c++) begin
         @(negedge clk);
         if (c == 3) lock = 1'b1;
         if (done === 1'b1 && dcyc < 0) dcyc = c;
      end
      checks++;
      if (dcyc != 10) begin failures++; $display("FAIL lock_midramp_done got=%0d exp=10", dcyc); end
      model[0] = t;
      t = model[0] ^ 2;
      valid = 1'b1; dly = DW'(t);
      bad = 1'b0;
      repeat (5) begin
         #1 if (ready !== 1'b0 || busy !== 1'b0) bad = 1'b1;
         @(negedge clk);
      end
      checks++;
      if (bad) begin failures++; $display("FAIL lock_hold_accept got=1 exp=0"); end
      lock = 1'b0;
      @(posedge clk);
      #1 valid = 1'b0;
      dcyc = -1;
      for (int c = 1; c <= 40; c++) begin
         @(negedge clk);
         if (done === 1'b1 && dcyc < 0) dcyc = c;
      end
      checks++;
      if (dcyc != 19) begin failures++; $display("FAIL lock_after_release_done got=%0d exp=19", dcyc); end
      model[0] = t;
   endtask
`endif

   initial begin
      test_reset();
      test_ramps();
      test_same_and_bad();
      test_back_to_back();
      test_abort();
`ifdef MC_DELAY_CTRL_LOCK_EN
      test_lock();
`endif
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
